// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game frame-buffer writer.
package game_pkg;

    localparam int unsigned AW_DEF = 6;
    localparam int unsigned DW_DEF = 6;

    // RGB222 colours, ordered {R[1:0],G[1:0],B[1:0]}
    localparam logic [5:0] RED   = 6'b110000;
    localparam logic [5:0] GREEN = 6'b001100;
    localparam logic [5:0] BLUE  = 6'b000011;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WR_OLD,
        WR_NEW
    } state_t;

endpackage

// File: rtl/button_debounce.sv
// Raw push-button to one-cycle rising-edge pulse: 2-FF sync, level debounce, edge detect.
module button_debounce #(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;
    logic          w_accept;

    // The level must differ for DEB_CYCLES consecutive cycles before it is taken
    assign w_accept = (r_sync[1] != r_stable) && (r_cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_in};
            r_pulse <= w_accept && r_sync[1];
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/game_px_writer.sv
// Button-driven cursor over a tile board, painted into the VGA frame buffer via its write port.
module game_px_writer
    import game_pkg::*;
#(
    parameter int unsigned     AW         = AW_DEF,
    parameter int unsigned     DW         = DW_DEF,
    parameter int unsigned     N_TILES    = 16,
    parameter int unsigned     DEB_CYCLES = 250000,
    parameter logic [DW-1:0]   BG_COLOR   = DW'(BLUE),
    parameter logic [DW-1:0]   TILE_COLOR = DW'(GREEN),
    parameter logic [DW-1:0]   CUR_COLOR  = DW'(RED)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in1,
    input  logic          in2,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic [3:0]    cursor,
    output logic          busy
);

    localparam int unsigned SW = AW + 1;

    logic          w_right;
    logic          w_left;

    state_t        r_state;
    logic [SW-1:0] r_sweep;
    logic [3:0]    r_cursor;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_wr;
    logic          r_busy;

    state_t        w_state_nxt;
    logic [SW-1:0] w_sweep_nxt;
    logic [3:0]    w_cursor_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] w_data_nxt;
    logic          w_wr_nxt;
    logic          w_busy_nxt;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_right (
        .clk    (clk),
        .rst    (rst),
        .btn_in (in1),
        .pulse  (w_right)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_left (
        .clk    (clk),
        .rst    (rst),
        .btn_in (in2),
        .pulse  (w_left)
    );

    // State names the phase whose write is on the outputs during this cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_sweep_nxt  = r_sweep;
        w_cursor_nxt = r_cursor;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_wr_nxt     = 1'b0;
        w_busy_nxt   = 1'b1;
        case (r_state)
            CLEAR: begin
                w_wr_nxt = 1'b1;
                if (r_sweep[AW]) begin
                    w_addr_nxt  = AW'(r_cursor);
                    w_data_nxt  = CUR_COLOR;
                    w_state_nxt = WR_NEW;
                end else begin
                    w_addr_nxt  = r_sweep[AW-1:0];
                    w_data_nxt  = (r_sweep < SW'(N_TILES)) ? TILE_COLOR : BG_COLOR;
                    w_sweep_nxt = r_sweep + SW'(1);
                end
            end
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_right ^ w_left) begin
                    if (w_right) begin
                        w_cursor_nxt = (r_cursor == 4'(N_TILES - 1)) ? 4'd0 : r_cursor + 4'd1;
                    end else begin
                        w_cursor_nxt = (r_cursor == 4'd0) ? 4'(N_TILES - 1) : r_cursor - 4'd1;
                    end
                    w_wr_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_addr_nxt  = AW'(r_cursor);
                    w_data_nxt  = TILE_COLOR;
                    w_state_nxt = WR_OLD;
                end
            end
            WR_OLD: begin
                w_wr_nxt    = 1'b1;
                w_addr_nxt  = AW'(r_cursor);
                w_data_nxt  = CUR_COLOR;
                w_state_nxt = WR_NEW;
            end
            WR_NEW: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= CLEAR;
            r_sweep  <= '0;
            r_cursor <= '0;
            r_addr   <= '0;
            r_data   <= BG_COLOR;
            r_wr     <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_sweep  <= w_sweep_nxt;
            r_cursor <= w_cursor_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_wr     <= w_wr_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign mem_px_addr = r_addr;
    assign mem_px_data = r_data;
    assign px_wr       = r_wr;
    assign cursor      = r_cursor;
    assign busy        = r_busy;

endmodule

// File: tb/tb_game_px_writer.sv
// Self-checking bench: shadow frame buffer compared with a tile/cursor image model.
module tb_game_px_writer;

    localparam logic [5:0] C_RED   = 6'b110000;
    localparam logic [5:0] C_GREEN = 6'b001100;
    localparam logic [5:0] C_BLUE  = 6'b000011;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in1 = 1'b0;
    logic       in2 = 1'b0;
    logic [5:0] mem_px_addr;
    logic [5:0] mem_px_data;
    logic       px_wr;
    logic [3:0] cursor;
    logic       busy;

    game_px_writer #(.AW(6), .DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .in1         (in1),
        .in2         (in2),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .cursor      (cursor),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [5:0] d;
        int         cyc;
    } wr_t;

    typedef struct {
        int d1;
        int h1;
        int d2;
        int h2;
        int exp_cur;
        int exp_nwr;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         mcur     = 0;
    logic [5:0] shadow [64];
    wr_t        wlog [$];

    // Frame buffer emulation: a write issued in a cycle lands at the next edge
    always @(negedge clk) begin
        cyc++;
        if (rst && px_wr) begin
            shadow[mem_px_addr] = mem_px_data;
            wlog.push_back('{a: mem_px_addr, d: mem_px_data, cyc: cyc});
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_image(input string name);
        int bad = 0;
        for (int a = 0; a < 64; a++) begin
            logic [5:0] e;
            e = (a >= 16) ? C_BLUE : ((a == mcur) ? C_RED : C_GREEN);
            if (shadow[a] !== e) bad++;
        end
        chk(name, bad, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},   int'(mem_px_addr), 0);
        chk({tag, "_data"},   int'(mem_px_data), int'(C_BLUE));
        chk({tag, "_wr"},     int'(px_wr), 0);
        chk({tag, "_cursor"}, int'(cursor), 0);
        chk({tag, "_busy"},   int'(busy), 1);
    endtask

    // Called right after rst was released on a negedge
    task automatic run_clear();
        int bad = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!(px_wr && busy && mem_px_addr == 6'(c) &&
                  mem_px_data == ((c < 16) ? C_GREEN : C_BLUE))) bad++;
        end
        chk("clear_sweep", bad, 0);
        @(negedge clk);
        chk("clear_wr_new", int'({px_wr, busy, mem_px_addr, mem_px_data}),
            int'({1'b1, 1'b1, 6'd0, C_RED}));
        @(negedge clk);
        chk("clear_busy_fall", int'(busy), 0);
        chk("clear_cursor", int'(cursor), 0);
        mcur = 0;
        chk_image("clear_image");
    endtask

    // Model: a press pulses iff held >= DEB cycles; pulses share latency, so the
    // order and spacing of the press starts is the order and spacing of pulses.
    task automatic run_vec(input string name, input int d1, input int h1,
                           input int d2, input int h2);
        wr_t exp [$];
        int  moves [$];
        bit  p1 = (h1 >= DEB);
        bit  p2 = (h2 >= DEB);
        int  bad = 0;
        int  n;
        if (p1 && p2) begin
            if (d1 < d2) begin
                moves.push_back(1);
                if (d2 - d1 >= 3) moves.push_back(-1);
            end else if (d2 < d1) begin
                moves.push_back(-1);
                if (d1 - d2 >= 3) moves.push_back(1);
            end
        end else if (p1) begin
            moves.push_back(1);
        end else if (p2) begin
            moves.push_back(-1);
        end
        foreach (moves[i]) begin
            int old = mcur;
            mcur = (mcur + 16 + moves[i]) % 16;
            exp.push_back('{a: 6'(old),  d: C_GREEN, cyc: 0});
            exp.push_back('{a: 6'(mcur), d: C_RED,   cyc: 0});
        end
        wlog.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in1 = (c >= d1) && (c < d1 + h1);
            in2 = (c >= d2) && (c < d2 + h2);
        end
        chk({name, "_nwr"}, wlog.size(), exp.size());
        n = (wlog.size() < exp.size()) ? wlog.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            if (wlog[i].a != exp[i].a || wlog[i].d != exp[i].d) bad++;
            if (i % 2 == 1 && wlog[i].cyc != wlog[i-1].cyc + 1) bad++;
        end
        chk({name, "_writes"}, bad, 0);
        chk({name, "_cursor"}, int'(cursor), mcur);
        chk_image({name, "_image"});
    endtask

    initial begin
        vec_t vt [10];
        int   hs [6] = '{0, 2, 3, 4, 5, 10};
        bit   found = 0;

        vt[0] = '{d1: 0, h1: 10, d2: 0, h2: 0,  exp_cur: 1,  exp_nwr: 2};
        vt[1] = '{d1: 0, h1: 0,  d2: 0, h2: 10, exp_cur: 0,  exp_nwr: 2};
        vt[2] = '{d1: 0, h1: 0,  d2: 0, h2: 10, exp_cur: 15, exp_nwr: 2};
        vt[3] = '{d1: 0, h1: 10, d2: 0, h2: 0,  exp_cur: 0,  exp_nwr: 2};
        vt[4] = '{d1: 0, h1: 10, d2: 0, h2: 10, exp_cur: 0,  exp_nwr: 0};
        vt[5] = '{d1: 0, h1: 3,  d2: 0, h2: 0,  exp_cur: 0,  exp_nwr: 0};
        vt[6] = '{d1: 0, h1: 10, d2: 1, h2: 10, exp_cur: 1,  exp_nwr: 2};
        vt[7] = '{d1: 2, h1: 10, d2: 0, h2: 10, exp_cur: 0,  exp_nwr: 2};
        vt[8] = '{d1: 0, h1: 10, d2: 3, h2: 10, exp_cur: 0,  exp_nwr: 4};
        vt[9] = '{d1: 0, h1: 4,  d2: 0, h2: 0,  exp_cur: 1,  exp_nwr: 2};

        #23;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b1;
        run_clear();

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i].d1, vt[i].h1, vt[i].d2, vt[i].h2);
            chk($sformatf("vec%0d_tbl_cursor", i), int'(cursor), vt[i].exp_cur);
            chk($sformatf("vec%0d_tbl_nwr", i), wlog.size(), vt[i].exp_nwr);
        end

        for (int i = 0; i < 25; i++) begin
            run_vec($sformatf("rnd%0d", i), $urandom_range(0, 4), hs[$urandom_range(0, 5)],
                    $urandom_range(0, 4), hs[$urandom_range(0, 5)]);
        end

        // Reset in the middle of a move, then a press during CLEAR that must be dropped
        @(negedge clk);
        in1 = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (px_wr && busy) found = 1;
        end
        chk("wr_old_seen", int'(found), 1);
        #1;
        rst = 1'b0;
        in1 = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fork
            run_clear();
            begin
                repeat (2) @(negedge clk);
                in1 = 1'b1;
                repeat (10) @(negedge clk);
                in1 = 1'b0;
            end
        join
        wlog.delete();
        repeat (20) @(negedge clk);
        chk("clear_press_dropped_nwr", wlog.size(), 0);
        chk("clear_press_dropped_cursor", int'(cursor), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
